// File: rtl/mem_axi_rd_arbiter.sv
// mem_axi_rd_arbiter: round-robin arbiter that shares one AXI read channel
// between an instruction-side (S0) and a data-side (S1) requester.
// Only one burst is in flight at a time.
//   CLK, RST            clock, synchronous active-high reset
//   S0_*/S1_*           requester AR request/accept and R beat delivery
//   M_AXI_*             shared AXI AR/R master interface
//   GRANT               one-hot owner (01 = S0, 10 = S1, 00 = none)
//   BUSY                a burst is in progress
//   PROTOERR            sticky RLAST/ARLEN mismatch flag
module mem_axi_rd_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] S0_ARADDR,
    input  logic [7:0]        S0_ARLEN,
    input  logic              S0_ARVALID,
    output logic              S0_ARREADY,
    output logic [DATA_W-1:0] S0_RDATA,
    output logic              S0_RLAST,
    output logic              S0_RVALID,
    input  logic              S0_RREADY,
    input  logic [ADDR_W-1:0] S1_ARADDR,
    input  logic [7:0]        S1_ARLEN,
    input  logic              S1_ARVALID,
    output logic              S1_ARREADY,
    output logic [DATA_W-1:0] S1_RDATA,
    output logic              S1_RLAST,
    output logic              S1_RVALID,
    input  logic              S1_RREADY,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic [7:0]        M_AXI_ARLEN,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [DATA_W-1:0] M_AXI_RDATA,
    input  logic              M_AXI_RLAST,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY,
    output logic [1:0]        GRANT,
    output logic              BUSY,
    output logic              PROTOERR
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b11
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] araddr_nxt;
    logic [7:0]        arlen_nxt;
    logic              arvalid_nxt;
    logic [1:0]        grant_nxt;
    logic              perr_nxt;
    logic              last_s1, last_s1_nxt;   // last burst owner was S1
    logic [7:0]        beat_cnt, beat_nxt;
    logic              win_s1;
    logic              rready_int;
    logic              beat_hs;

    assign BUSY = (state != IDLE);

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARLEN   <= '0;
            M_AXI_ARVALID <= 1'b0;
            GRANT         <= 2'b00;
            PROTOERR      <= 1'b0;
            last_s1       <= 1'b1;
            beat_cnt      <= '0;
        end else begin
            state         <= state_nxt;
            M_AXI_ARADDR  <= araddr_nxt;
            M_AXI_ARLEN   <= arlen_nxt;
            M_AXI_ARVALID <= arvalid_nxt;
            GRANT         <= grant_nxt;
            PROTOERR      <= perr_nxt;
            last_s1       <= last_s1_nxt;
            beat_cnt      <= beat_nxt;
        end
    end

    // Next-state, arbitration and combinational R routing
    always_comb begin
        state_nxt    = state;
        araddr_nxt   = M_AXI_ARADDR;
        arlen_nxt    = M_AXI_ARLEN;
        arvalid_nxt  = M_AXI_ARVALID;
        grant_nxt    = GRANT;
        perr_nxt     = PROTOERR;
        last_s1_nxt  = last_s1;
        beat_nxt     = beat_cnt;
        win_s1       = 1'b0;
        rready_int   = 1'b0;
        beat_hs      = 1'b0;
        S0_ARREADY   = 1'b0;
        S1_ARREADY   = 1'b0;
        S0_RDATA     = '0;
        S0_RLAST     = 1'b0;
        S0_RVALID    = 1'b0;
        S1_RDATA     = '0;
        S1_RLAST     = 1'b0;
        S1_RVALID    = 1'b0;
        M_AXI_RREADY = 1'b0;

        // Reset suppresses every handshake even while the old state is still visible
        if (!RST) begin
            case (state)
                IDLE: begin
                    if (S0_ARVALID || S1_ARVALID) begin
                        // On a tie, the requester that did not own the last burst wins
                        win_s1      = S1_ARVALID && (!S0_ARVALID || !last_s1);
                        S0_ARREADY  = !win_s1;
                        S1_ARREADY  = win_s1;
                        araddr_nxt  = win_s1 ? S1_ARADDR : S0_ARADDR;
                        arlen_nxt   = win_s1 ? S1_ARLEN  : S0_ARLEN;
                        arvalid_nxt = 1'b1;
                        grant_nxt   = win_s1 ? 2'b10 : 2'b01;
                        state_nxt   = ADDR;
                    end
                end
                ADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_nxt = 1'b0;
                        beat_nxt    = 8'd0;
                        state_nxt   = DATA;
                    end
                end
                DATA: begin
                    S0_RVALID    = GRANT[0] & M_AXI_RVALID;
                    S0_RLAST     = GRANT[0] & M_AXI_RLAST;
                    S0_RDATA     = GRANT[0] ? M_AXI_RDATA : '0;
                    S1_RVALID    = GRANT[1] & M_AXI_RVALID;
                    S1_RLAST     = GRANT[1] & M_AXI_RLAST;
                    S1_RDATA     = GRANT[1] ? M_AXI_RDATA : '0;
                    rready_int   = (GRANT[0] & S0_RREADY) | (GRANT[1] & S1_RREADY);
                    M_AXI_RREADY = rready_int;
                    beat_hs      = M_AXI_RVALID & rready_int;
                    if (beat_hs) begin
                        beat_nxt = beat_cnt + 8'd1;
                        // RLAST must coincide exactly with beat index == ARLEN
                        if (M_AXI_RLAST != (beat_cnt == M_AXI_ARLEN)) begin
                            perr_nxt = 1'b1;
                        end
                        if (M_AXI_RLAST) begin
                            last_s1_nxt = GRANT[1];
                            grant_nxt   = 2'b00;
                            state_nxt   = IDLE;
                        end
                    end
                end
                default: begin
                    arvalid_nxt = 1'b0;
                    grant_nxt   = 2'b00;
                    state_nxt   = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_axi_rd_arbiter.sv
// Scoreboard bench for mem_axi_rd_arbiter: expected AR transfers and R beats
// are queued as stimulus is issued; a negedge monitor pops and compares them.
module tb_mem_axi_rd_arbiter;

    logic        CLK;
    logic        RST;
    logic [31:0] S0_ARADDR, S1_ARADDR;
    logic [7:0]  S0_ARLEN, S1_ARLEN;
    logic        S0_ARVALID, S1_ARVALID;
    logic        S0_ARREADY, S1_ARREADY;
    logic [31:0] S0_RDATA, S1_RDATA;
    logic        S0_RLAST, S1_RLAST;
    logic        S0_RVALID, S1_RVALID;
    logic        S0_RREADY, S1_RREADY;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic        M_AXI_RLAST;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;
    logic [1:0]  GRANT;
    logic        BUSY;
    logic        PROTOERR;

    int n_chk  = 0;
    int n_pass = 0;

    logic [39:0] exp_ar[$];   // {addr, len}
    logic [33:0] exp_r[$];    // {id, last, data}

    mem_axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .S0_ARADDR(S0_ARADDR), .S0_ARLEN(S0_ARLEN), .S0_ARVALID(S0_ARVALID),
        .S0_ARREADY(S0_ARREADY), .S0_RDATA(S0_RDATA), .S0_RLAST(S0_RLAST),
        .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY),
        .S1_ARADDR(S1_ARADDR), .S1_ARLEN(S1_ARLEN), .S1_ARVALID(S1_ARVALID),
        .S1_ARREADY(S1_ARREADY), .S1_RDATA(S1_RDATA), .S1_RLAST(S1_RLAST),
        .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RLAST(M_AXI_RLAST),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .GRANT(GRANT), .BUSY(BUSY), .PROTOERR(PROTOERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compare every AR handshake and every delivered beat with the queues
    always @(negedge CLK) begin
        if (!RST) begin
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                if (exp_ar.size() == 0) chk("ar_unexpected", 64'({M_AXI_ARADDR, M_AXI_ARLEN}), 64'hFFFF_FFFF_FFFF);
                else chk("ar_xfer", 64'({M_AXI_ARADDR, M_AXI_ARLEN}), 64'(exp_ar.pop_front()));
            end
            if (S0_RVALID && S1_RVALID) chk("rvalid_both", 64'({S0_RVALID, S1_RVALID}), 64'(2'b00));
            if (S0_RVALID && S0_RREADY) begin
                if (exp_r.size() == 0) chk("s0_beat_unexpected", 64'({1'b0, S0_RLAST, S0_RDATA}), 64'h3_FFFF_FFFF_F);
                else chk("s0_beat", 64'({1'b0, S0_RLAST, S0_RDATA}), 64'(exp_r.pop_front()));
            end
            if (S1_RVALID && S1_RREADY) begin
                if (exp_r.size() == 0) chk("s1_beat_unexpected", 64'({1'b1, S1_RLAST, S1_RDATA}), 64'h3_FFFF_FFFF_F);
                else chk("s1_beat", 64'({1'b1, S1_RLAST, S1_RDATA}), 64'(exp_r.pop_front()));
            end
        end
    end

    task automatic set_rready(input bit id, input logic v);
        if (id) S1_RREADY = v;
        else    S0_RREADY = v;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        S0_ARVALID = 1'b1;          // a request during reset must not be accepted
        M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_ARREADY = 1'b0;
        cyc();
        cyc();
        #1;
        chk("rst_arready", 64'({S0_ARREADY, S1_ARREADY}), 64'(2'b00));
        chk("rst_rvalid", 64'({S0_RVALID, S1_RVALID}), 64'(2'b00));
        S0_ARVALID = 1'b0; S1_ARVALID = 1'b0;
        RST = 1'b0;
        #1;
        chk("rst_grant", 64'(GRANT), 64'(2'b00));
        chk("rst_busy", 64'(BUSY), 64'(1'b0));
        chk("rst_perr", 64'(PROTOERR), 64'(1'b0));
        chk("rst_ar", 64'({M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN}), 64'(0));
    endtask

    // One complete burst for requester id, starting in an IDLE cycle
    task automatic run_burst(input bit id, input logic [31:0] addr, input logic [7:0] len,
                             input int ar_wait, input int nbeats, input int rlast_idx,
                             input int stall);
        logic [1:0]  g;
        logic [31:0] d;
        logic        l;
        g = id ? 2'b10 : 2'b01;
        if (id) begin S1_ARVALID = 1'b1; S1_ARADDR = addr; S1_ARLEN = len; end
        else    begin S0_ARVALID = 1'b1; S0_ARADDR = addr; S0_ARLEN = len; end
        #1;
        chk("arready_win", 64'({S1_ARREADY, S0_ARREADY}), 64'(g));
        exp_ar.push_back({addr, len});
        cyc();
        if (id) S1_ARVALID = 1'b0; else S0_ARVALID = 1'b0;
        M_AXI_ARREADY = (ar_wait == 0);
        #1;
        chk("grant", 64'(GRANT), 64'(g));
        chk("arvalid_set", 64'(M_AXI_ARVALID), 64'(1'b1));
        chk("busy", 64'(BUSY), 64'(1'b1));
        chk("arready_pulse", 64'({S1_ARREADY, S0_ARREADY}), 64'(2'b00));
        for (int w = 1; w <= ar_wait; w++) begin
            cyc();
            M_AXI_ARREADY = (w == ar_wait);
            #1;
            chk("ar_hold", 64'({M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN}), 64'({1'b1, addr, len}));
        end
        cyc();
        M_AXI_ARREADY = 1'b0;
        #1;
        chk("arvalid_drop", 64'(M_AXI_ARVALID), 64'(1'b0));
        for (int i = 0; i < nbeats; i++) begin
            d = addr ^ 32'hA5A5_0000 ^ 32'(i);
            l = (i == rlast_idx);
            M_AXI_RVALID = 1'b1; M_AXI_RDATA = d; M_AXI_RLAST = l;
            if (i == 0) begin
                for (int s = 0; s < stall; s++) begin
                    set_rready(id, 1'b0);
                    #1;
                    chk("stall_rready", 64'(M_AXI_RREADY), 64'(1'b0));
                    chk("stall_rvalid", 64'({S1_RVALID, S0_RVALID}), 64'(g));
                    cyc();
                end
            end
            set_rready(id, 1'b1);
            exp_r.push_back({id, l, d});
            #1;
            chk("m_rready", 64'(M_AXI_RREADY), 64'(1'b1));
            cyc();
        end
        M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
        #1;
        chk("grant_clear", 64'(GRANT), 64'(2'b00));
        chk("idle", 64'(BUSY), 64'(1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        S0_ARADDR = '0; S0_ARLEN = '0; S0_ARVALID = 1'b0; S0_RREADY = 1'b1;
        S1_ARADDR = '0; S1_ARLEN = '0; S1_ARVALID = 1'b0; S1_RREADY = 1'b1;
        M_AXI_ARREADY = 1'b0; M_AXI_RDATA = '0; M_AXI_RLAST = 1'b0; M_AXI_RVALID = 1'b0;
        cyc();
        do_reset();

        // Single S0 burst, AR accepted after two wait cycles, four beats
        run_burst(1'b0, 32'h0000_1000, 8'd3, 2, 4, 3, 0);
        // Tie after an S0 burst: S1 wins, then S0 follows after one IDLE cycle
        S0_ARVALID = 1'b1; S0_ARADDR = 32'h0000_1100; S0_ARLEN = 8'd0;
        run_burst(1'b1, 32'h0000_1200, 8'd1, 0, 2, 1, 0);
        run_burst(1'b0, 32'h0000_1100, 8'd0, 0, 1, 0, 0);

        // Tie straight after reset: S0 first, S1 next, then S0 wins the next tie
        do_reset();
        S1_ARVALID = 1'b1; S1_ARADDR = 32'h0000_3000; S1_ARLEN = 8'd1;
        run_burst(1'b0, 32'h0000_2000, 8'd0, 0, 1, 0, 0);
        run_burst(1'b1, 32'h0000_3000, 8'd1, 1, 2, 1, 0);
        S1_ARVALID = 1'b1; S1_ARADDR = 32'h0000_3100; S1_ARLEN = 8'd0;
        run_burst(1'b0, 32'h0000_2100, 8'd0, 0, 1, 0, 0);
        run_burst(1'b1, 32'h0000_3100, 8'd0, 0, 1, 0, 0);

        // S1 single beat with its RREADY held low three cycles
        run_burst(1'b1, 32'h0000_4000, 8'd0, 0, 1, 0, 3);
        chk("perr_clean", 64'(PROTOERR), 64'(1'b0));

        // Early RLAST on beat 2 of 4, then a clean burst: error stays sticky
        run_burst(1'b0, 32'h0000_5000, 8'd3, 0, 3, 2, 0);
        chk("perr_early", 64'(PROTOERR), 64'(1'b1));
        run_burst(1'b1, 32'h0000_5100, 8'd1, 0, 2, 1, 0);
        chk("perr_sticky", 64'(PROTOERR), 64'(1'b1));
        do_reset();
        // Missing RLAST on the ARLEN beat also flags the error
        run_burst(1'b0, 32'h0000_5200, 8'd0, 0, 2, 1, 0);
        chk("perr_late", 64'(PROTOERR), 64'(1'b1));
        do_reset();

        // Reset in DATA after the first of four beats
        S0_ARVALID = 1'b1; S0_ARADDR = 32'h0000_6000; S0_ARLEN = 8'd3;
        #1;
        chk("ab_arready", 64'(S0_ARREADY), 64'(1'b1));
        exp_ar.push_back({32'h0000_6000, 8'd3});
        cyc();
        S0_ARVALID = 1'b0; M_AXI_ARREADY = 1'b1;
        cyc();
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'h6666_0000; M_AXI_RLAST = 1'b0;
        exp_r.push_back({1'b0, 1'b0, 32'h6666_0000});
        cyc();
        M_AXI_RDATA = 32'h6666_0001;
        RST = 1'b1;
        #1;
        chk("ab_rst_rvalid", 64'({S1_RVALID, S0_RVALID}), 64'(2'b00));
        chk("ab_rst_rready", 64'(M_AXI_RREADY), 64'(1'b0));
        cyc();
        RST = 1'b0;
        for (int k = 2; k < 4; k++) begin
            M_AXI_RDATA = 32'h6666_0000 + 32'(k);
            M_AXI_RLAST = (k == 3);
            #1;
            chk("ab_grant", 64'(GRANT), 64'(2'b00));
            chk("ab_busy", 64'(BUSY), 64'(1'b0));
            chk("ab_stray_rready", 64'(M_AXI_RREADY), 64'(1'b0));
            chk("ab_stray_rvalid", 64'({S1_RVALID, S0_RVALID}), 64'(2'b00));
            cyc();
        end
        M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
        run_burst(1'b1, 32'h0000_7000, 8'd1, 0, 2, 1, 0);

        cyc();
        chk("ar_queue_empty", 64'(exp_ar.size()), 64'(0));
        chk("r_queue_empty", 64'(exp_r.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_axi_rd_arbiter.md
MEM_AXI_RD_ARBITER -- requirements
Module: mem_axi_rd_arbiter

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- ADDR_W, 32, address width
- DATA_W, 32, data width

REQ-002 The block SHALL have the following ports (name, direction, width, meaning), with reset RST synchronous, active-high, and clock CLK:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- S0_ARADDR / S1_ARADDR  in  ADDR_W  requester read address (S0 = instruction side, S1 = data side)
- S0_ARLEN / S1_ARLEN  in  8  requester burst length minus 1
- S0_ARVALID / S1_ARVALID  in  1  requester read request
- S0_ARREADY / S1_ARREADY  out  1  request accepted, one-cycle pulse
- S0_RDATA / S1_RDATA  out  DATA_W  read beat data
- S0_RLAST / S1_RLAST  out  1  last beat
- S0_RVALID / S1_RVALID  out  1  beat valid
- S0_RREADY / S1_RREADY  in  1  requester beat accept
- M_AXI_ARADDR  out  ADDR_W  shared AXI AR address
- M_AXI_ARLEN  out  8  shared AXI AR length
- M_AXI_ARVALID  out  1  shared AXI AR valid
- M_AXI_ARREADY  in  1  slave AR ready
- M_AXI_RDATA  in  DATA_W  slave read data
- M_AXI_RLAST  in  1  slave last beat
- M_AXI_RVALID  in  1  slave beat valid
- M_AXI_RREADY  out  1  beat accept to slave
- GRANT  out  2  one-hot current owner: 01 = S0, 10 = S1, 00 = none
- BUSY  out  1  state != IDLE
- PROTOERR  out  1  sticky burst-length mismatch flag

Function
REQ-003 The block SHALL implement three states:
- IDLE = 00
- ADDR = 01
- DATA = 11
- unused encoding 10 returns to IDLE.

REQ-004 In IDLE, when any Sn_ARVALID=1, the block SHALL:
- select the winner (REQ-005);
- pulse the winner's Sn_ARREADY for exactly that cycle (combinational);
- register the winner's ARADDR/ARLEN into M_AXI_ARADDR/M_AXI_ARLEN;
- set M_AXI_ARVALID=1 and GRANT to the winner;
- enter ADDR at the next edge.

REQ-005 Arbitration SHALL be round-robin:
- with a single requester, that requester wins;
- when both request in the same cycle, the requester not granted last wins;
- the last-granted pointer resets to S1, so S0 wins the first tie.

REQ-006 In ADDR, M_AXI_ARADDR, M_AXI_ARLEN and M_AXI_ARVALID SHALL hold stable until M_AXI_ARREADY=1. On that cycle the block SHALL deassert M_AXI_ARVALID at the next edge and enter DATA.

REQ-007 Latency: Sn_ARVALID sampled in IDLE at cycle t SHALL produce M_AXI_ARVALID=1 at cycle t+1.

REQ-008 In DATA, routing SHALL be combinational:
- M_AXI_RDATA, M_AXI_RLAST and M_AXI_RVALID route to the granted requester only; the non-granted Sn_RVALID stays 0.
- M_AXI_RREADY equals the granted Sn_RREADY.

REQ-009 An 8-bit beat counter SHALL:
- clear on entry to DATA;
- increment on each M_AXI_RVALID & M_AXI_RREADY;
- compare against the latched ARLEN.

REQ-010 On a handshake with M_AXI_RLAST=1, the block SHALL:
- return to IDLE;
- clear GRANT;
- update the last-granted pointer to the burst owner.

REQ-011 If M_AXI_RLAST=1 arrives on a beat whose index != latched ARLEN, or the beat with index == ARLEN arrives with M_AXI_RLAST=0, the block SHALL:
- set PROTOERR=1 (sticky until RST);
- terminate the burst only on RLAST.

REQ-012 Outside DATA, M_AXI_RREADY SHALL be 0 and Sn_RVALID SHALL be 0. Beats arriving in IDLE or ADDR are not accepted.

REQ-013 A requester that asserts ARVALID while the other owns the bus SHALL wait with ARREADY=0. Its request is considered in the first IDLE cycle after the current burst; there are no idle bubbles beyond that one IDLE cycle.

REQ-014 Only one outstanding burst SHALL exist at a time; the block never issues a second AR before RLAST of the current burst.

Reset
REQ-015 While RST=1 at a clock edge, the block SHALL:
- set state = IDLE;
- set M_AXI_ARVALID=0, M_AXI_ARADDR=0, M_AXI_ARLEN=0;
- set GRANT=00, BUSY=0, PROTOERR=0;
- set the last-granted pointer to S1;
- clear the beat counter;
- hold all Sn_ARREADY and Sn_RVALID at 0.

REQ-016 RST asserted mid-burst (ADDR or DATA) SHALL abandon the burst without draining. Subsequent stray R beats SHALL be ignored (M_AXI_RREADY=0) until a new grant reaches DATA.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Single S0 request, ARADDR=0x1000, ARLEN=3, ARREADY delayed 2 cycles → S0_ARREADY pulses 1 cycle; M_AXI_ARADDR=0x1000 and ARLEN=3 held 3 cycles; 4 beats reach S0 only; GRANT 01→00 after RLAST.
- S0 and S1 request the same cycle after reset → S0 served first; S1 served next with exactly one IDLE cycle between bursts; the pointer then favours S0 on the next tie.
- S1 burst ARLEN=0 with S1_RREADY low 3 cycles → M_AXI_RREADY=0 for those 3 cycles; the beat is delivered when RREADY rises; S0_RVALID stays 0 throughout.
- ARLEN=3 with RLAST on beat 2 → PROTOERR=1, return to IDLE; PROTOERR stays 1 through the next clean burst until RST.
- RST during DATA after beat 1 of 4 → next cycle IDLE, GRANT=00, M_AXI_RREADY=0; the remaining slave beats are not accepted; a new S1 request is then served normally.
